// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if
//   Byte handshake between an upstream producer and the UART transmitter.
//   A byte moves at a rising clock edge where tx_valid and tx_ready are both high.
//   Signals:
//     tx_data   8  byte offered by the producer
//     tx_valid  1  tx_data is valid this cycle
//     tx_ready  1  transmitter FIFO can take a byte this cycle
//   Modports:
//     master  producer side (drives tx_data/tx_valid)
//     slave   transmitter side (drives tx_ready)
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   8N1 UART transmitter fed by a small circular byte FIFO. Bytes are sent
//   LSB first; queued bytes go out back-to-back with no idle gap between the
//   stop bit of one frame and the start bit of the next.
// Parameters:
//   CLK_FREQ    input clock frequency in Hz
//   BAUD        line rate in bit/s
//   FIFO_DEPTH  FIFO entries (power of two, >= 2)
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   bus         slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   Tx          serial line, idle high, driven from a flop
//   tx_busy     a frame is on the line or bytes are waiting
//   fifo_count  bytes waiting in the FIFO (the byte in the shifter is not counted)
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               bus,
  output logic                        Tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;
  localparam int BW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t          state_q,  state_d;
  logic [BW-1:0]   baud_q,   baud_d;
  logic [2:0]      bit_q,    bit_d;
  logic [7:0]      shift_q,  shift_d;
  logic            tx_q,     tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            tx_ready;
  logic            push;
  logic            pop;
  logic            baud_end;
  logic            fifo_nonempty;

  // ---------------------------------------------------------------------------
  // FIFO handshake and bookkeeping
  // ---------------------------------------------------------------------------
  // Ready comes only from the registered count, so a full FIFO refuses a byte
  // even on the edge where the FSM pops; the slot is offered one cycle later.
  assign tx_ready      = (count_q < FIFO_FULL);
  assign push          = bus.tx_valid & tx_ready;
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM: next state, pop request and shifter
  // ---------------------------------------------------------------------------
  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = START;
        end
      end

      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when a byte is waiting.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // The line level is computed from the next state so the registered Tx
  // always matches the state register after the same edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state: control is reset, datapath storage is not
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wr_ptr_q] <= bus.tx_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.tx_ready = tx_ready;
  assign Tx           = tx_q;
  assign tx_busy      = (state_q != IDLE) | fifo_nonempty;
  assign fifo_count   = count_q;

endmodule
